i2c_txn_arbiter: RTL and testbench

- Shares the single I2C generator (master) between two requesters, e.g. the config sequencer and the host register interface.
- Arbitrates round-robin, latches the winner's command and drives one START_STB to the generator.
- Tracks completion with a timeout, then returns read data and error status to the winner.
- Sits directly in front of the I2C generator; the generator and this block share clk and rst.

---
 rtl/i2c_txn_arbiter.sv | 118 +++++++++++
 tb/tb_i2c_txn_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin front end for a single I2C generator.
// Latches the winner's command, fires one START_STB, waits for GEN_DONE
// or a timeout, then returns read data / error status with a one-cycle ACK.
module i2c_txn_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 512,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              RNW0,
    input  logic              RNW1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              TIMEOUT,
    output logic              BUSY,
    output logic              START_STB,
    output logic              RNW,
    output logic [ADDR_W-1:0] I2C_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    input  logic              GEN_DONE,
    input  logic              GEN_NACK,
    input  logic [DATA_W-1:0] GEN_RD_DATA
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StDone} state_e;

    // Counter value at which an unanswered transaction is forced to complete.
    localparam logic [15:0] ToLast = 16'(TIMEOUT_CYC - 1);

    state_e      state;
    logic        grant_idx;
    logic        last_idx;   // requester served most recently
    logic [15:0] cnt;
    logic [15:0] cnt_inc;
    logic        pick1;

    // Winner select: sole requester wins; on contention the one not served last.
    always_comb begin
        pick1   = REQ1 & (~REQ0 | ~last_idx);
        cnt_inc = cnt + 16'd1;
    end

    // Arbitration / transaction FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            grant_idx <= 1'b0;
            last_idx  <= 1'b1;  // makes first contention go to requester 0
            cnt       <= '0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            RDATA     <= '0;
            ERR       <= 1'b0;
            TIMEOUT   <= 1'b0;
            BUSY      <= 1'b0;
            START_STB <= 1'b0;
            RNW       <= 1'b0;
            I2C_ADDR  <= '0;
            WR_DATA   <= '0;
        end else begin
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            START_STB <= 1'b0;
            case (state)
                StIdle: begin
                    if (REQ0 || REQ1) begin
                        grant_idx <= pick1;
                        RNW       <= pick1 ? RNW1 : RNW0;
                        I2C_ADDR  <= pick1 ? ADDR1 : ADDR0;
                        WR_DATA   <= pick1 ? WDATA1 : WDATA0;
                        BUSY      <= 1'b1;
                        START_STB <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    cnt   <= '0;
                    state <= StWait;
                end
                StWait: begin
                    cnt <= cnt_inc;
                    // A GEN_DONE on the timeout cycle still counts as normal completion.
                    if (GEN_DONE) begin
                        RDATA   <= RNW ? GEN_RD_DATA : '0;
                        ERR     <= GEN_NACK;
                        TIMEOUT <= 1'b0;
                        ACK0    <= ~grant_idx;
                        ACK1    <= grant_idx;
                        state   <= StDone;
                    end else if (cnt_inc == ToLast) begin
                        RDATA   <= '0;
                        ERR     <= 1'b1;
                        TIMEOUT <= 1'b1;
                        ACK0    <= ~grant_idx;
                        ACK1    <= grant_idx;
                        state   <= StDone;
                    end
                end
                StDone: begin
                    last_idx <= grant_idx;
                    BUSY     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter with an ACK scoreboard.
module tb_i2c_txn_arbiter;

    logic        clk;
    logic        rst;
    logic        REQ0, REQ1, RNW0, RNW1;
    logic [6:0]  ADDR0, ADDR1;
    logic [15:0] WDATA0, WDATA1;
    logic        ACK0, ACK1;
    logic [15:0] RDATA;
    logic        ERR, TIMEOUT, BUSY, START_STB, RNW;
    logic [6:0]  I2C_ADDR;
    logic [15:0] WR_DATA;
    logic        GEN_DONE, GEN_NACK;
    logic [15:0] GEN_RD_DATA;

    typedef struct packed {
        logic        idx;
        logic [15:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   stb_cnt = 0;

    i2c_txn_arbiter #(.TIMEOUT_CYC(16), .ADDR_W(7), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .REQ0(REQ0), .REQ1(REQ1), .RNW0(RNW0), .RNW1(RNW1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR), .TIMEOUT(TIMEOUT),
        .BUSY(BUSY), .START_STB(START_STB), .RNW(RNW), .I2C_ADDR(I2C_ADDR),
        .WR_DATA(WR_DATA), .GEN_DONE(GEN_DONE), .GEN_NACK(GEN_NACK),
        .GEN_RD_DATA(GEN_RD_DATA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every ACK must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (START_STB) stb_cnt++;
        if (rst && (ACK0 || ACK1)) begin
            chk("ack_onehot", {ACK0, ACK1} == 2'b11, 0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {ACK1, ACK0}, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_idx", ACK1, e.idx);
                chk("ack_rdata", RDATA, e.rdata);
                chk("ack_err", ERR, e.err);
                chk("ack_timeout_flag", TIMEOUT, e.tmo);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (START_STB) seen = 1;
        end
        if (!seen) chk("start_stb_wait", 0, 1);
    endtask

    // One-cycle GEN_DONE; ACK of the granted requester must follow on the next edge.
    task automatic done_pulse(input logic idx, input logic nack, input logic [15:0] rd,
                              input logic [15:0] exp_rd);
        sb.push_back({idx, exp_rd, nack, 1'b0});
        GEN_DONE = 1'b1;
        GEN_NACK = nack;
        GEN_RD_DATA = rd;
        step();
        GEN_DONE = 1'b0;
        GEN_NACK = 1'b0;
        chk("ack_latency", idx ? ACK1 : ACK0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, {ACK1, ACK0}, 0);
        chk({tag, "_stb"}, START_STB, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_rnw"}, RNW, 0);
        chk({tag, "_addr"}, I2C_ADDR, 0);
        chk({tag, "_wdata"}, WR_DATA, 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_err"}, ERR, 0);
        chk({tag, "_tmo"}, TIMEOUT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        REQ0 = 0; REQ1 = 0; RNW0 = 0; RNW1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        GEN_DONE = 0; GEN_NACK = 0; GEN_RD_DATA = '0;
        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        step();
        rst = 1'b1;

        // Single write
        REQ0 = 1; RNW0 = 0; ADDR0 = 7'h3D; WDATA0 = 16'h1234;
        step();
        chk("wr_stb", START_STB, 1);
        chk("wr_addr", I2C_ADDR, 7'h3D);
        chk("wr_wdata", WR_DATA, 16'h1234);
        chk("wr_rnw", RNW, 0);
        chk("wr_busy", BUSY, 1);
        WDATA0 = 16'hDEAD;  // post-grant change must be ignored
        step();
        chk("wr_stb_once", START_STB, 0);
        chk("wr_wdata_hold", WR_DATA, 16'h1234);
        repeat (3) step();
        done_pulse(0, 0, 16'hFFFF, 16'h0000);
        REQ0 = 0;
        step();
        chk("wr_busy_clr", BUSY, 0);

        // Single read from requester 1
        REQ1 = 1; RNW1 = 1; ADDR1 = 7'h3D;
        step();
        chk("rd_stb", START_STB, 1);
        chk("rd_rnw", RNW, 1);
        repeat (2) step();
        done_pulse(1, 0, 16'h5678, 16'h5678);
        chk("rd_ack0_low", ACK0, 0);
        REQ1 = 0;
        step();

        // Bad address -> NACK
        REQ0 = 1; RNW0 = 0; ADDR0 = 7'h7D;
        wait_stb(5);
        chk("nack_addr", I2C_ADDR, 7'h7D);
        step();
        done_pulse(0, 1, 16'h0000, 16'h0000);
        REQ0 = 0;
        step();

        // Reset during WAIT aborts without ACK
        REQ0 = 1; RNW0 = 1; ADDR0 = 7'h50;
        wait_stb(5);
        repeat (5) step();
        rst = 1'b0;
        #1 chk_all_zero("midrst");
        step();
        step();
        rst = 1'b1;
        step();
        chk("midrst_restart", START_STB, 1);
        step();
        done_pulse(0, 0, 16'hABCD, 16'hABCD);
        REQ0 = 0;
        step();

        // Timeout with TIMEOUT_CYC=16
        REQ0 = 1; RNW0 = 1; ADDR0 = 7'h21;
        wait_stb(5);
        sb.push_back({1'b0, 16'h0000, 1'b1, 1'b1});
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("tmo_early_ack", ACK0, 0);
        end
        step();
        chk("tmo_ack", ACK0, 1);
        chk("tmo_busy_done", BUSY, 1);
        REQ0 = 0;
        step();
        chk("tmo_busy_clr", BUSY, 0);
        GEN_DONE = 1; GEN_RD_DATA = 16'h9999;
        step();
        GEN_DONE = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("late_done_ack", {ACK1, ACK0}, 0);
            chk("late_done_busy", BUSY, 0);
        end

        // Contention after reset: order 0,1,0,1
        rst = 1'b0;
        step();
        rst = 1'b1;
        base = stb_cnt;
        ADDR0 = 7'h11; ADDR1 = 7'h22; RNW0 = 0; RNW1 = 0;
        WDATA0 = 16'h0A0A; WDATA1 = 16'h0B0B;
        REQ0 = 1; REQ1 = 1;
        for (int n = 0; n < 4; n++) begin
            logic idx;
            idx = n[0];
            wait_stb(6);
            chk("rr_addr", I2C_ADDR, idx ? 7'h22 : 7'h11);
            chk("rr_wdata", WR_DATA, idx ? 16'h0B0B : 16'h0A0A);
            step();
            done_pulse(idx, 0, 16'h0000, 16'h0000);
            if (n == 3) begin
                REQ0 = 0; REQ1 = 0;
            end
        end
        repeat (4) step();
        chk("rr_stb_count", stb_cnt - base, 4);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
